// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register with valid/ready handshake, optional
// two-entry skid buffer, synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 296,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              take_in, take_out;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    out_valid = (state_q != StEmpty);
    // With the skid buffer, in_ready is a pure state decode (no path from out_ready).
    if (SKID_EN) begin
      in_ready = (state_q != StSkid);
    end else begin
      in_ready = !out_valid || out_ready;
    end
    take_in  = in_valid && in_ready;
    take_out = out_valid && out_ready;

    case (state_q)
      StEmpty: begin
        if (take_in) begin
          main_d  = in_data;
          state_d = StFull;
        end
      end
      StFull: begin
        if (take_in && take_out) begin
          main_d = in_data;
        end else if (take_out) begin
          state_d = StEmpty;
        end else if (take_in) begin
          // Only reachable with SKID_EN: without it in_ready is low here.
          skid_d  = in_data;
          state_d = StSkid;
        end
      end
      StSkid: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = StFull;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (flush) begin
      state_d = StEmpty;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end

    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data    = main_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid (index 0) and combinational-ready (index 1)
// builds checked every cycle against an occupancy/FIFO reference model.
module tb_pipe_stage_reg;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic          clock, reset;
  logic          iv[2], ir[2], ov[2], ordy[2], fl[2];
  logic [DW-1:0] id[2], od[2];
  logic [CW-1:0] sc[2];

  int n_checks, n_fail;

  // Reference model: occupancy, held beats in order, last shown value, stall cycles.
  int            occ[2];
  logic [DW-1:0] ent[2][2];
  logic [DW-1:0] last[2];
  int            cnt[2];

  // Upstream source used by the directed streaming tests.
  logic [DW-1:0] src[8];
  int            sptr[2];
  int            slen;

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(CW)) dut_skid (
    .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .flush(fl[0]),
    .stall_count(sc[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID_EN(1'b0), .CNT_W(CW)) dut_comb (
    .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .flush(fl[1]),
    .stall_count(sc[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_ready(input int i);
    if (i == 0) return occ[i] < 2;
    return (occ[i] == 0) || ordy[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      occ[i]  = 0;
      last[i] = '0;
      cnt[i]  = 0;
    end
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic step();
    logic push[2], pop[2];
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("out_valid[%0d]", i), 64'(ov[i]), 64'(occ[i] > 0));
      check($sformatf("in_ready[%0d]", i), 64'(ir[i]), 64'(exp_ready(i)));
      check($sformatf("out_data[%0d]", i), 64'(od[i]),
            64'((occ[i] > 0) ? ent[i][0] : last[i]));
      check($sformatf("stall_count[%0d]", i), 64'(sc[i]), 64'(cnt[i]));
      pop[i]  = (occ[i] > 0) && ordy[i];
      push[i] = iv[i] && exp_ready(i);
    end
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      if ((occ[i] > 0) && !ordy[i] && (cnt[i] < SAT)) cnt[i]++;
      if (push[i] && !fl[i]) sptr[i]++;
      if (fl[i]) begin
        occ[i]  = 0;
        last[i] = '0;
      end else begin
        if (pop[i]) begin
          last[i]   = ent[i][0];
          ent[i][0] = ent[i][1];
          occ[i]--;
        end
        if (push[i]) begin
          ent[i][occ[i]] = id[i];
          occ[i]++;
        end
      end
    end
    #1;
  endtask

  task automatic drive_src();
    for (int i = 0; i < 2; i++) begin
      iv[i] = sptr[i] < slen;
      id[i] = (sptr[i] < slen) ? src[sptr[i]] : '0;
      fl[i] = 1'b0;
    end
  endtask

  task automatic drive_all(input logic v, input logic [DW-1:0] d, input logic r,
                           input logic f);
    for (int i = 0; i < 2; i++) begin
      iv[i]   = v;
      id[i]   = d;
      ordy[i] = r;
      fl[i]   = f;
    end
  endtask

  initial begin
    logic [9:0] pat;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive_all(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) sptr[i] = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Stream 8 beats with downstream always ready.
    for (int k = 0; k < 8; k++) src[k] = DW'(k + 1);
    slen = 8;
    for (int c = 0; c < 11; c++) begin
      drive_src();
      for (int i = 0; i < 2; i++) ordy[i] = 1'b1;
      step();
    end
    for (int i = 0; i < 2; i++) check($sformatf("stream8_drained[%0d]", i), 64'(sptr[i]), 64'd8);

    // A,B,C with three cycles of backpressure after A is presented.
    src[0] = 32'hA; src[1] = 32'hB; src[2] = 32'hC;
    slen = 3;
    for (int i = 0; i < 2; i++) sptr[i] = 0;
    pat = 10'b11_1111_0001;
    for (int c = 0; c < 10; c++) begin
      drive_src();
      for (int i = 0; i < 2; i++) ordy[i] = pat[c];
      step();
    end
    for (int i = 0; i < 2; i++) check($sformatf("abc_drained[%0d]", i), 64'(sptr[i]), 64'd3);

    // Flush while the skid entry is occupied and a new beat is offered.
    drive_all(1'b1, 32'h11, 1'b0, 1'b0); step();
    drive_all(1'b1, 32'h22, 1'b0, 1'b0); step();
    drive_all(1'b1, 32'hDEAD, 1'b0, 1'b1); step();
    drive_all(1'b0, '0, 1'b1, 1'b0); step();
    step();

    // Stall counter saturation, survives flush.
    drive_all(1'b1, 32'h33, 1'b0, 1'b0); step();
    drive_all(1'b0, '0, 1'b0, 1'b0);
    repeat (21) step();
    drive_all(1'b0, '0, 1'b0, 1'b1); step();
    drive_all(1'b0, '0, 1'b0, 1'b0); step();

    // Asynchronous reset mid-cycle while FULL.
    drive_all(1'b1, 32'h44, 1'b0, 1'b0); step();
    drive_all(1'b0, '0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("async_rst_out_valid[%0d]", i), 64'(ov[i]), 64'd0);
      check($sformatf("async_rst_out_data[%0d]", i), 64'(od[i]), 64'd0);
      check($sformatf("async_rst_in_ready[%0d]", i), 64'(ir[i]), 64'd1);
      check($sformatf("async_rst_stall[%0d]", i), 64'(sc[i]), 64'd0);
    end
    model_reset();
    #1 reset = 1'b0;
    step();

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]   = 1'($urandom_range(0, 1));
        id[i]   = $urandom;
        ordy[i] = ($urandom_range(0, 9) < 6);
        fl[i]   = ($urandom_range(0, 15) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic inter-stage register for the five-stage pipeline CPU, replacing the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB latches. Carries one packed bundle of stage fields per beat with a valid/ready handshake, an optional two-entry skid buffer for registered backpressure, synchronous flush for bubble insertion, and a saturating stall-cycle counter. Every storage element has a defined reset value.

## Interface
- DATA_W, 32*9+4+4 = 296: width of the packed stage bundle (Inst, NewPC, RegDataA/B, Imm, ALUOutput, MemData, etc. concatenated by the instantiating stage)
- RESET_VAL, all zeros: value loaded into out_data on reset and on flush; represents a NOP bubble
- SKID_EN, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- CNT_W, 16: stall counter width

- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream beat present
- in_ready  out  1  this stage accepts a beat this cycle
- in_data  in  DATA_W  upstream bundle
- out_valid  out  1  out_data holds a valid beat
- out_ready  in  1  downstream accepts a beat this cycle
- out_data  out  DATA_W  bundle presented to next stage
- flush  in  1  synchronous squash of all held and incoming beats
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready at a rising edge.
- States (SKID_EN=1): EMPTY, FULL (main entry valid), SKID (main and skid entries valid).
  - EMPTY: out_valid=0, in_ready=1. in_valid -> main<=in_data, FULL.
  - FULL: out_valid=1, in_ready=1. in_valid & out_ready -> main<=in_data, stay. !in_valid & out_ready -> EMPTY. in_valid & !out_ready -> skid<=in_data, SKID. Neither -> hold.
  - SKID: out_valid=1, in_ready=0. out_ready -> main<=skid, FULL. Otherwise hold.
  - in_ready is a decode of state only (no combinational path from out_ready).
- SKID_EN=0: states EMPTY/FULL only; in_ready = !out_valid | out_ready (combinational); FULL with in_valid & out_ready replaces main; FULL with !in_valid & out_ready -> EMPTY.
- out_data is always the main entry; it retains its last value when EMPTY after drain (valid-qualified).
- flush (highest priority, synchronous): next state EMPTY, main and skid <= RESET_VAL, input beat of the flush cycle discarded even if in_valid & in_ready; an output transfer in that cycle still counts as completed downstream.
- stall_count: increments by 1 each cycle with out_valid & !out_ready, saturates at 2^CNT_W-1, unaffected by flush, cleared only by reset.
- Reset (async, any time incl. mid-transfer): state EMPTY, out_valid=0, in_ready=1 (both SKID_EN modes), out_data=RESET_VAL, skid=RESET_VAL, stall_count=0. Beats in flight are lost.

## Timing
- Latency: in_data accepted at edge N appears on out_data with out_valid=1 after edge N (visible cycle N+1).
- Throughput: one beat per cycle when out_ready held high, both modes.
- SKID_EN=1: in_ready drops the cycle after a beat lands in skid; restores the cycle after skid drains into main. At most one extra beat is accepted after out_ready falls.
- No beat duplicated or dropped except by flush/reset; order preserved.
- Reset release: first in_valid may be accepted at the first rising edge after reset deasserts.

## Test plan
- Stream 8 beats 0x1..0x8, out_ready=1: out_data 0x1..0x8 on consecutive cycles, one cycle latency, stall_count=0.
- SKID_EN=1, stream A,B,C, drop out_ready after A presented for 3 cycles: B in skid, in_ready=0 from next cycle, C held upstream; on release out sequence A,B,C, stall_count=3.
- SKID_EN=0, same stimulus: in_ready follows out_ready same cycle, no beat lost, out sequence A,B,C.
- Flush in SKID state with in_valid=1 (data 0xDEAD): next cycle out_valid=0, out_data=RESET_VAL, in_ready=1, 0xDEAD never appears at output.
- Hold out_valid=1, out_ready=0 for 2^CNT_W+5 cycles (CNT_W=4 build): stall_count sticks at 15; flush does not clear it; reset does.
- Assert reset asynchronously mid-cycle while FULL: out_valid=0, out_data=RESET_VAL immediately, before next clock edge.
